fft_channel_scheduler: RTL and testbench
========================================

FFT_CHANNEL_SCHEDULER -- requirements
Module: fft_channel_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of ADC requester channels (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, maximum RUN-state cycles per frame.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ch_req, input, NUM_CH, per-channel frame request.
REQ-006 SHALL have port ch_adc_data, input, NUM_CH*16, Q1.15 samples; channel k occupies bits [16k+15:16k].
REQ-007 SHALL have port ch_adc_valid, input, NUM_CH, per-channel sample strobe.
REQ-008 SHALL have port ch_grant, output, NUM_CH, one-hot grant; all zero when no frame is active.
REQ-009 SHALL have port fft_enable, output, 1, enable to the FFT processor.
REQ-010 SHALL have ports fft_adc_input (output, 16) and fft_adc_valid (output, 1), the muxed sample stream.
REQ-011 SHALL have port fft_ready_for_data, input, 1, FFT sampling-ready flag.
REQ-012 SHALL have ports fft_magnitude (input, 28, Q13.15), fft_bin_index (input, 11) and fft_magnitude_valid (input, 1).
REQ-013 SHALL have port fft_processing_done, input, 1, FFT frame-complete level.
REQ-014 SHALL have ports peak_mag (output, 28), peak_bin (output, 11) and peak_ch (output, clog2(NUM_CH)), the last frame result.
REQ-015 SHALL have ports result_valid (output, 1, one-cycle pulse), busy (output, 1) and timeout_err (output, 1, one-cycle pulse).

Function
REQ-016 SHALL implement states IDLE, RUN, REPORT, RELEASE.
REQ-017 IDLE: when any ch_req is set, SHALL grant the first requesting channel searching upward from last_granted+1 (mod NUM_CH), register it, assert ch_grant and fft_enable next cycle, and enter RUN.
REQ-018 The round-robin pointer SHALL update only on grant; the first grant after reset SHALL search from channel 0.
REQ-019 RUN: fft_adc_input SHALL equal the granted channel's data combinationally, and fft_adc_valid SHALL equal ch_adc_valid[g] AND fft_ready_for_data; ungranted channels SHALL be ignored.
REQ-020 RUN: peak_acc SHALL clear on RUN entry; on each fft_magnitude_valid with 1 <= fft_bin_index <= 1023, peak_acc SHALL update when fft_magnitude > peak_acc (strict; ties keep the lower bin); DC and the upper half SHALL be excluded.
REQ-021 RUN: fft_processing_done SHALL be accepted only after it has been sampled low at least once in the current RUN (this rejects the stale level from the previous frame); on acceptance SHALL enter REPORT.
REQ-022 REPORT: SHALL load peak_mag, peak_bin and peak_ch, pulse result_valid for one cycle, drop fft_enable and ch_grant, and enter RELEASE.
REQ-023 RELEASE: SHALL hold fft_enable low for exactly 2 cycles, then enter IDLE; a new grant SHALL NOT occur earlier.
REQ-024 The peak outputs SHALL hold their value until the next REPORT.
REQ-025 busy SHALL be high in every state except IDLE.
REQ-026 Deassertion of ch_req by the granted channel during RUN SHALL NOT abort the frame.
REQ-027 If a frame finds no bin above zero, REPORT SHALL output peak_mag=0 and peak_bin=0.

Reset
REQ-028 On rst_n low, regardless of state: state=IDLE, all outputs=0, peak_acc=0, RR pointer=NUM_CH-1, timeout counter=0; an in-flight frame SHALL be discarded without result_valid.

Configuration
REQ-029 With macro FFT_SCHED_TIMEOUT_EN defined: a counter SHALL start at RUN entry; on reaching TIMEOUT_CYCLES in RUN, the block SHALL pulse timeout_err, skip REPORT (no result_valid, peak outputs unchanged) and enter RELEASE.
REQ-030 Without FFT_SCHED_TIMEOUT_EN: no counter SHALL be present, timeout_err SHALL be tied 0, and RUN SHALL wait indefinitely.

Structure
REQ-031 Package fft_sched_pkg SHALL hold the state encoding, MAG_W=28, BIN_W=11, SAMPLE_W=16, the half-spectrum limit of 1023 and the default NUM_CH.
REQ-032 Round-robin selection SHALL be implemented in sub-module rr_arbiter (inputs: req and pointer; outputs: one-hot grant and index).

Verification
REQ-033 Single request on ch2; FFT model returns bin 37 with magnitude 0x0123456 and all others smaller -> exactly one result_valid with peak_ch=2, peak_bin=37, peak_mag=0x0123456.
REQ-034 ch0, ch1 and ch3 requesting continuously -> grants in the order 0,1,3,0,1,3; each fft_enable low gap is 3 cycles or more.
REQ-035 Equal magnitude 0x100 at bins 5 and 9, 0x200 at bin 0 and bin 1500 -> peak_bin=5, peak_mag=0x100.
REQ-036 processing_done held high from the previous frame at RUN entry -> no REPORT until done falls and then rises again.
REQ-037 FFT_SCHED_TIMEOUT_EN with TIMEOUT_CYCLES=50 and done never asserted -> timeout_err pulses on RUN cycle 50, no result_valid, and the next channel is granted after RELEASE.
REQ-038 rst_n low mid-RUN -> all outputs 0 immediately; no result_valid; the first grant after reset goes to the lowest requesting channel.

Source files
------------

// File: rtl/fft_sched_pkg.sv
// rtl/fft_sched_pkg.sv - shared widths, limits and FSM encoding for the FFT channel scheduler
package fft_sched_pkg;

    localparam int MAG_W          = 28;
    localparam int BIN_W          = 11;
    localparam int SAMPLE_W       = 16;
    localparam int HALF_LIMIT     = 1023;
    localparam int DEFAULT_NUM_CH = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_REPORT  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/fft_channel_scheduler_if.sv
// rtl/fft_channel_scheduler_if.sv - channel request and FFT-side signal bundle
interface fft_channel_scheduler_if
    import fft_sched_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH
);
    logic [NUM_CH-1:0]          ch_req;
    logic [NUM_CH*SAMPLE_W-1:0] ch_adc_data;
    logic [NUM_CH-1:0]          ch_adc_valid;
    logic [NUM_CH-1:0]          ch_grant;
    logic                       fft_enable;
    logic [SAMPLE_W-1:0]        fft_adc_input;
    logic                       fft_adc_valid;
    logic                       fft_ready_for_data;
    logic [MAG_W-1:0]           fft_magnitude;
    logic [BIN_W-1:0]           fft_bin_index;
    logic                       fft_magnitude_valid;
    logic                       fft_processing_done;
    logic [MAG_W-1:0]           peak_mag;
    logic [BIN_W-1:0]           peak_bin;
    logic [$clog2(NUM_CH)-1:0]  peak_ch;
    logic                       result_valid;
    logic                       busy;
    logic                       timeout_err;

    modport slave (
        input  ch_req, ch_adc_data, ch_adc_valid, fft_ready_for_data,
               fft_magnitude, fft_bin_index, fft_magnitude_valid, fft_processing_done,
        output ch_grant, fft_enable, fft_adc_input, fft_adc_valid,
               peak_mag, peak_bin, peak_ch, result_valid, busy, timeout_err
    );

    modport master (
        output ch_req, ch_adc_data, ch_adc_valid, fft_ready_for_data,
               fft_magnitude, fft_bin_index, fft_magnitude_valid, fft_processing_done,
        input  ch_grant, fft_enable, fft_adc_input, fft_adc_valid,
               peak_mag, peak_bin, peak_ch, result_valid, busy, timeout_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first requester above the pointer
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        // Search wraps from ptr+1 and ends at ptr itself, so the last winner goes last.
        for (int i = 1; i <= NUM_CH; i++) begin
            w_cand = IDX_W'((int'(ptr) + i) % NUM_CH);
            if (!w_found && req[w_cand]) begin
                w_found        = 1'b1;
                grant[w_cand]  = 1'b1;
                idx            = w_cand;
            end
        end
    end

endmodule

// File: rtl/fft_channel_scheduler.sv
// rtl/fft_channel_scheduler.sv - time-shares one FFT among ADC channels and reports per-frame peak
// Optional RUN watchdog enabled by FFT_SCHED_TIMEOUT_EN.
module fft_channel_scheduler
    import fft_sched_pkg::*;
#(
    parameter int NUM_CH         = DEFAULT_NUM_CH,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_channel_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_CH);

    state_t             r_state, w_next;
    logic [IDX_W-1:0]   r_ptr, r_idx, w_arb_idx;
    logic [NUM_CH-1:0]  w_arb_grant;
    logic               w_any_req, w_accept, w_timeout, w_upd;
    logic               r_done_seen_low, r_rel_cnt;
    logic [MAG_W-1:0]   r_peak_acc, w_cand_mag, r_peak_mag;
    logic [BIN_W-1:0]   r_peak_bin_acc, w_cand_bin, r_peak_bin;
    logic [IDX_W-1:0]   r_peak_ch;
    logic [SAMPLE_W-1:0] w_sample;

    rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
        .req   (bus.ch_req),
        .ptr   (r_ptr),
        .grant (w_arb_grant),
        .idx   (w_arb_idx)
    );

    assign w_any_req = |w_arb_grant;
    // A done level is only trusted once it has been seen low in this frame.
    assign w_accept  = (r_state == S_RUN) && bus.fft_processing_done && r_done_seen_low;
    assign w_upd     = bus.fft_magnitude_valid && (bus.fft_bin_index != '0)
                     && (bus.fft_bin_index <= BIN_W'(HALF_LIMIT))
                     && (bus.fft_magnitude > r_peak_acc);
    assign w_cand_mag = w_upd ? bus.fft_magnitude : r_peak_acc;
    assign w_cand_bin = w_upd ? bus.fft_bin_index : r_peak_bin_acc;

`ifdef FFT_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_to_cnt <= '0;
        else if (r_state == S_RUN)  r_to_cnt <= r_to_cnt + TO_W'(1);
        else                        r_to_cnt <= '0;
    end

    assign w_timeout = (r_state == S_RUN) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_any_req) w_next = S_RUN;
            S_RUN:     if (w_accept) w_next = S_REPORT;
                       else if (w_timeout) w_next = S_RELEASE;
            S_REPORT:  w_next = S_RELEASE;
            S_RELEASE: if (r_rel_cnt) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr           <= IDX_W'(NUM_CH - 1);
            r_idx           <= '0;
            r_done_seen_low <= 1'b0;
            r_rel_cnt       <= 1'b0;
            r_peak_acc      <= '0;
            r_peak_bin_acc  <= '0;
            r_peak_mag      <= '0;
            r_peak_bin      <= '0;
            r_peak_ch       <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_any_req) begin
                    r_idx           <= w_arb_idx;
                    r_ptr           <= w_arb_idx;
                    r_done_seen_low <= 1'b0;
                    r_peak_acc      <= '0;
                    r_peak_bin_acc  <= '0;
                end
                S_RUN: begin
                    if (!bus.fft_processing_done) r_done_seen_low <= 1'b1;
                    r_peak_acc     <= w_cand_mag;
                    r_peak_bin_acc <= w_cand_bin;
                    if (w_accept) begin
                        r_peak_mag <= w_cand_mag;
                        r_peak_bin <= w_cand_bin;
                        r_peak_ch  <= r_idx;
                    end
                end
                S_REPORT:  r_rel_cnt <= 1'b0;
                S_RELEASE: r_rel_cnt <= ~r_rel_cnt;
                default:   r_rel_cnt <= 1'b0;
            endcase
        end
    end

    always_comb begin
        w_sample = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_idx == IDX_W'(k)) w_sample = bus.ch_adc_data[k*SAMPLE_W +: SAMPLE_W];
        end
    end

    always_comb begin
        bus.ch_grant      = '0;
        bus.fft_enable    = 1'b0;
        bus.fft_adc_input = '0;
        bus.fft_adc_valid = 1'b0;
        if (r_state == S_RUN) begin
            bus.ch_grant[r_idx] = 1'b1;
            bus.fft_enable      = 1'b1;
            bus.fft_adc_input   = w_sample;
            bus.fft_adc_valid   = bus.ch_adc_valid[r_idx] && bus.fft_ready_for_data;
        end
        bus.result_valid = (r_state == S_REPORT);
        bus.busy         = (r_state != S_IDLE);
        bus.timeout_err  = w_timeout;
        bus.peak_mag     = r_peak_mag;
        bus.peak_bin     = r_peak_bin;
        bus.peak_ch      = r_peak_ch;
    end

endmodule

// File: tb/tb_fft_channel_scheduler.sv
// tb/tb_fft_channel_scheduler.sv - directed self-checking bench for fft_channel_scheduler
module tb_fft_channel_scheduler;
    import fft_sched_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fft_channel_scheduler_if #(.NUM_CH(4)) bus();

    fft_channel_scheduler #(.NUM_CH(4), .TIMEOUT_CYCLES(50)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task tick();
        @(posedge clk);
        #1;
    endtask

    task idle_inputs();
        bus.ch_req              = '0;
        bus.ch_adc_data         = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
        bus.ch_adc_valid        = '0;
        bus.fft_ready_for_data  = 1'b1;
        bus.fft_magnitude       = '0;
        bus.fft_bin_index       = '0;
        bus.fft_magnitude_valid = 1'b0;
        bus.fft_processing_done = 1'b0;
    endtask

    task automatic send_bin(input int b, input int m);
        bus.fft_bin_index       = 11'(b);
        bus.fft_magnitude       = 28'(m);
        bus.fft_magnitude_valid = 1'b1;
        tick();
        bus.fft_magnitude_valid = 1'b0;
    endtask

    task finish_frame();
        bus.fft_processing_done = 1'b0;
        tick();
        bus.fft_processing_done = 1'b1;
        tick();
    endtask

    task automatic wait_idle();
        int g = 0;
        while (bus.busy !== 1'b0 && g < 20) begin g++; tick(); end
        n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL wait_idle busy=%b exp=0", bus.busy); end
    endtask

    task automatic wait_enable(output int gap);
        gap = 0;
        while (bus.fft_enable !== 1'b1 && gap < 20) begin gap++; tick(); end
        n_vec++;
        if (bus.fft_enable !== 1'b1) begin n_err++; $display("FAIL wait_enable got=%b exp=1", bus.fft_enable); end
    endtask

    task test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        n_vec++; if (bus.ch_grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got=%b exp=0000", bus.ch_grant); end
        n_vec++; if ({bus.fft_enable, bus.busy, bus.result_valid, bus.timeout_err, bus.fft_adc_valid} !== 5'b0)
            begin n_err++; $display("FAIL reset_ctrl got=%b exp=00000", {bus.fft_enable, bus.busy, bus.result_valid, bus.timeout_err, bus.fft_adc_valid}); end
        n_vec++; if ({bus.peak_mag, bus.peak_bin, bus.peak_ch} !== '0)
            begin n_err++; $display("FAIL reset_peak got=%h/%0d/%0d exp=0/0/0", bus.peak_mag, bus.peak_bin, bus.peak_ch); end
        n_vec++; if (bus.fft_adc_input !== 16'h0) begin n_err++; $display("FAIL reset_adc got=%h exp=0000", bus.fft_adc_input); end
        rst_n = 1'b1;
        tick();
    endtask

    task test_single_request();
        int rv = 0;
        bus.ch_req = 4'b0100;
        tick();
        n_vec++; if (bus.ch_grant !== 4'b0100) begin n_err++; $display("FAIL single_grant got=%b exp=0100", bus.ch_grant); end
        n_vec++; if ({bus.fft_enable, bus.busy} !== 2'b11) begin n_err++; $display("FAIL single_enable got=%b exp=11", {bus.fft_enable, bus.busy}); end
        bus.ch_req = 4'b0000;
        bus.ch_adc_valid = 4'b0100;
        #1;
        n_vec++; if ({bus.fft_adc_input, bus.fft_adc_valid} !== {16'hBEEF, 1'b1})
            begin n_err++; $display("FAIL mux_data got=%h/%b exp=beef/1", bus.fft_adc_input, bus.fft_adc_valid); end
        bus.fft_ready_for_data = 1'b0;
        #1;
        n_vec++; if (bus.fft_adc_valid !== 1'b0) begin n_err++; $display("FAIL mux_ready got=%b exp=0", bus.fft_adc_valid); end
        bus.fft_ready_for_data = 1'b1;
        bus.ch_adc_valid = 4'b1011;
        #1;
        n_vec++; if (bus.fft_adc_valid !== 1'b0) begin n_err++; $display("FAIL mux_other got=%b exp=0", bus.fft_adc_valid); end
        bus.ch_adc_valid = 4'b0000;
        for (int b = 30; b <= 40; b++) send_bin(b, (b == 37) ? 32'h0123456 : 32'h0100000 + b);
        finish_frame();
        n_vec++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL single_rv got=%b exp=1", bus.result_valid); end
        n_vec++; if ({bus.peak_ch, bus.peak_bin, bus.peak_mag} !== {2'd2, 11'd37, 28'h0123456})
            begin n_err++; $display("FAIL single_peak got=%0d/%0d/%h exp=2/37/0123456", bus.peak_ch, bus.peak_bin, bus.peak_mag); end
        n_vec++; if ({bus.fft_enable, bus.ch_grant} !== 5'b0) begin n_err++; $display("FAIL report_drop got=%b/%b exp=0/0000", bus.fft_enable, bus.ch_grant); end
        bus.fft_processing_done = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); rv += int'(bus.result_valid); end
        n_vec++; if (rv != 0) begin n_err++; $display("FAIL single_once extra_pulses=%0d exp=0", rv); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_idle busy=%b exp=0", bus.busy); end
    endtask

    task test_peak_tie();
        bus.ch_req = 4'b0001;
        tick();
        n_vec++; if (bus.ch_grant !== 4'b0001) begin n_err++; $display("FAIL tie_grant got=%b exp=0001", bus.ch_grant); end
        bus.ch_req = 4'b0000;
        n_vec++; if (bus.peak_mag !== 28'h0123456) begin n_err++; $display("FAIL peak_hold got=%h exp=0123456", bus.peak_mag); end
        send_bin(0, 'h200); send_bin(5, 'h100); send_bin(9, 'h100);
        send_bin(1500, 'h200); send_bin(1024, 'h300); send_bin(1023, 'h0FF);
        finish_frame();
        n_vec++; if ({bus.result_valid, bus.peak_ch, bus.peak_bin, bus.peak_mag} !== {1'b1, 2'd0, 11'd5, 28'h100})
            begin n_err++; $display("FAIL tie_peak got=%b/%0d/%0d/%h exp=1/0/5/100", bus.result_valid, bus.peak_ch, bus.peak_bin, bus.peak_mag); end
        bus.fft_processing_done = 1'b0;
        wait_idle();
    endtask

    task test_no_peak();
        bus.ch_req = 4'b1000;
        tick();
        n_vec++; if (bus.ch_grant !== 4'b1000) begin n_err++; $display("FAIL nopeak_grant got=%b exp=1000", bus.ch_grant); end
        bus.ch_req = 4'b0000;
        send_bin(0, 'h500); send_bin(2000, 'h500); send_bin(3, 0);
        finish_frame();
        n_vec++; if ({bus.result_valid, bus.peak_ch, bus.peak_bin, bus.peak_mag} !== {1'b1, 2'd3, 11'd0, 28'h0})
            begin n_err++; $display("FAIL nopeak_peak got=%b/%0d/%0d/%h exp=1/3/0/0", bus.result_valid, bus.peak_ch, bus.peak_bin, bus.peak_mag); end
        bus.fft_processing_done = 1'b0;
        wait_idle();
    endtask

    task test_stale_done();
        int rv = 0;
        bus.ch_req = 4'b0010;
        bus.fft_processing_done = 1'b1;
        tick();
        n_vec++; if (bus.ch_grant !== 4'b0010) begin n_err++; $display("FAIL stale_grant got=%b exp=0010", bus.ch_grant); end
        bus.ch_req = 4'b0000;
        for (int i = 0; i < 6; i++) begin tick(); rv += int'(bus.result_valid); end
        n_vec++; if (rv != 0 || bus.fft_enable !== 1'b1)
            begin n_err++; $display("FAIL stale_hold pulses=%0d en=%b exp=0/1", rv, bus.fft_enable); end
        bus.fft_processing_done = 1'b0;
        tick();
        n_vec++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL stale_low got=%b exp=0", bus.result_valid); end
        bus.fft_processing_done = 1'b1;
        tick();
        n_vec++; if ({bus.result_valid, bus.peak_ch} !== {1'b1, 2'd1})
            begin n_err++; $display("FAIL stale_report got=%b/%0d exp=1/1", bus.result_valid, bus.peak_ch); end
        bus.fft_processing_done = 1'b0;
        wait_idle();
    endtask

    task test_round_robin();
        logic [3:0] exp_g [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        int gap;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.ch_req = 4'b1011;
        for (int f = 0; f < 6; f++) begin
            wait_enable(gap);
            n_vec++; if (bus.ch_grant !== exp_g[f])
                begin n_err++; $display("FAIL rr_order frame=%0d got=%b exp=%b", f, bus.ch_grant, exp_g[f]); end
            if (f > 0) begin
                n_vec++; if (gap < 3) begin n_err++; $display("FAIL rr_gap frame=%0d got=%0d exp>=3", f, gap); end
            end
            finish_frame();
            bus.fft_processing_done = 1'b0;
        end
        bus.ch_req = 4'b0000;
        wait_idle();
    endtask

    task test_reset_mid_run();
        int rv = 0;
        bus.ch_req = 4'b0110;
        tick();
        send_bin(7, 'h7777); send_bin(8, 'h8888);
        bus.ch_adc_valid = 4'b0110;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if ({bus.ch_grant, bus.fft_enable, bus.busy, bus.fft_adc_valid, bus.result_valid} !== 8'b0)
            begin n_err++; $display("FAIL midrst_ctrl got=%b/%b/%b/%b exp=0000/0/0/0", bus.ch_grant, bus.fft_enable, bus.busy, bus.fft_adc_valid); end
        n_vec++; if ({bus.peak_mag, bus.fft_adc_input} !== '0)
            begin n_err++; $display("FAIL midrst_data got=%h/%h exp=0/0", bus.peak_mag, bus.fft_adc_input); end
        bus.fft_processing_done = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); rv += int'(bus.result_valid); end
        n_vec++; if (rv != 0) begin n_err++; $display("FAIL midrst_rv pulses=%0d exp=0", rv); end
        bus.fft_processing_done = 1'b0;
        bus.ch_adc_valid = 4'b0000;
        rst_n = 1'b1;
        tick();
        n_vec++; if (bus.ch_grant !== 4'b0010) begin n_err++; $display("FAIL midrst_first got=%b exp=0010", bus.ch_grant); end
    endtask

    task test_timeout();
        int bad = 0;
        int gap;
`ifdef FFT_SCHED_TIMEOUT_EN
        for (int i = 1; i < 50; i++) begin
            if (bus.timeout_err !== 1'b0 || bus.result_valid !== 1'b0) bad++;
            tick();
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL to_early bad_cycles=%0d exp=0", bad); end
        n_vec++; if (bus.timeout_err !== 1'b1) begin n_err++; $display("FAIL to_pulse got=%b exp=1", bus.timeout_err); end
        tick();
        n_vec++; if ({bus.timeout_err, bus.result_valid, bus.fft_enable, bus.busy} !== 4'b0001)
            begin n_err++; $display("FAIL to_release got=%b exp=0001", {bus.timeout_err, bus.result_valid, bus.fft_enable, bus.busy}); end
`else
        for (int i = 0; i < 60; i++) begin
            if (bus.timeout_err !== 1'b0 || bus.fft_enable !== 1'b1) bad++;
            tick();
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL no_to bad_cycles=%0d exp=0", bad); end
        finish_frame();
        n_vec++; if ({bus.result_valid, bus.peak_ch} !== {1'b1, 2'd1})
            begin n_err++; $display("FAIL no_to_report got=%b/%0d exp=1/1", bus.result_valid, bus.peak_ch); end
        bus.fft_processing_done = 1'b0;
`endif
        wait_enable(gap);
        n_vec++; if (bus.ch_grant !== 4'b0100) begin n_err++; $display("FAIL to_next got=%b exp=0100", bus.ch_grant); end
        bus.ch_req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_peak_tie();
        test_no_peak();
        test_stale_done();
        test_round_robin();
        test_reset_mid_run();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
